alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 141 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_exec_unit                                              |
// | Description : RV32I-style integer ALU execute stage with a valid/ready   |
// |               handshake on both sides and a registered result.           |
// |               FSM states IDLE / BUSY / DONE.                             |
// |               Optional macro ALU_SERIAL_SHIFT_EN: shifts with a non-zero |
// |               shift amount run one bit per cycle in BUSY. Without it,    |
// |               shifts use a barrel shifter and every op is single-cycle.  |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid / in_ready   - operation handshake                |
// |               alu_a, alu_b, alu_op  - operands, op = {funct7[5],funct3}  |
// |               out_valid / out_ready - result handshake                   |
// |               result, zero          - registered result, result == 0     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b1000;
  localparam logic [3:0] c_OP_SLL  = 4'b0001;
  localparam logic [3:0] c_OP_SLT  = 4'b0010;
  localparam logic [3:0] c_OP_SLTU = 4'b0011;
  localparam logic [3:0] c_OP_XOR  = 4'b0100;
  localparam logic [3:0] c_OP_SRL  = 4'b0101;
  localparam logic [3:0] c_OP_SRA  = 4'b1101;
  localparam logic [3:0] c_OP_OR   = 4'b0110;
  localparam logic [3:0] c_OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_result;

  logic              w_accept;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_alu_res;

`ifdef ALU_SERIAL_SHIFT_EN
  logic [4:0] r_cnt;       // remaining single-bit shift steps
  logic       r_sh_right;  // funct3[2]: 0 = left, 1 = right
  logic       r_sh_arith;  // funct7[5]: arithmetic right shift
  logic       w_is_shift;

  assign w_is_shift = (alu_op == c_OP_SLL) || (alu_op == c_OP_SRL) ||
                      (alu_op == c_OP_SRA);
`endif

  // A completing result may be consumed and replaced in the same cycle.
  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = ~|r_result;   // from the register, never the inputs
  assign w_shamt   = alu_b[4:0];

  // Single-cycle datapath; also the barrel shifter when shifts are parallel.
  always_comb begin
    w_alu_res = '0;
    case (alu_op)
      c_OP_ADD:  w_alu_res = alu_a + alu_b;
      c_OP_SUB:  w_alu_res = alu_a - alu_b;
      c_OP_SLL:  w_alu_res = alu_a << w_shamt;
      c_OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      c_OP_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
      c_OP_XOR:  w_alu_res = alu_a ^ alu_b;
      c_OP_SRL:  w_alu_res = alu_a >> w_shamt;
      c_OP_SRA:  w_alu_res = $signed(alu_a) >>> w_shamt;
      c_OP_OR:   w_alu_res = alu_a | alu_b;
      c_OP_AND:  w_alu_res = alu_a & alu_b;
      default:   w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_result   <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
      r_cnt      <= 5'd0;
      r_sh_right <= 1'b0;
      r_sh_arith <= 1'b0;
`endif
    end else begin
      case (r_state)
`ifdef ALU_SERIAL_SHIFT_EN
        BUSY: begin
          if (r_sh_right)
            r_result <= {r_sh_arith & r_result[DATA_W-1], r_result[DATA_W-1:1]};
          else
            r_result <= {r_result[DATA_W-2:0], 1'b0};
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1)
            r_state <= DONE;
        end
`endif
        default: begin  // IDLE and DONE
          if (w_accept) begin
`ifdef ALU_SERIAL_SHIFT_EN
            // Load the operand unshifted; BUSY then takes shamt steps.
            if (w_is_shift && (w_shamt != 5'd0)) begin
              r_state    <= BUSY;
              r_result   <= alu_a;
              r_cnt      <= w_shamt;
              r_sh_right <= alu_op[2];
              r_sh_arith <= alu_op[3];
            end else
`endif
            begin
              r_state  <= DONE;
              r_result <= w_alu_res;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_exec_unit                                           |
// | Description : Scoreboard bench for alu_exec_unit. Accepted operations   |
// |               push a reference result; completed transfers pop and      |
// |               compare result and zero. Latency expectations follow      |
// |               ALU_SERIAL_SHIFT_EN when it is defined.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_exec_unit;

  localparam logic [3:0] c_ADD = 4'b0000, c_SUB = 4'b1000, c_SLL = 4'b0001,
                         c_SLT = 4'b0010, c_SLTU = 4'b0011, c_XOR = 4'b0100,
                         c_SRL = 4'b0101, c_SRA = 4'b1101, c_OR = 4'b0110,
                         c_AND = 4'b0111;
`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit c_SERIAL = 1'b1;
`else
  localparam bit c_SERIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_a = '0;
  logic [31:0] alu_b = '0;
  logic [3:0]  alu_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [31:0] sb_q[$];

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      c_ADD:   return a + b;
      c_SUB:   return a - b;
      c_SLL:   return a << b[4:0];
      c_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      c_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      c_XOR:   return a ^ b;
      c_SRL:   return a >> b[4:0];
      c_SRA:   return sa >>> b[4:0];
      c_OR:    return a | b;
      c_AND:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [31:0] b, input logic [3:0] op);
    if (c_SERIAL && (op == c_SLL || op == c_SRL || op == c_SRA) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Pop before push so a same-cycle accept never satisfies its own check.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check("sb_result", result, exp);
          check("sb_zero", {31'd0, zero}, {31'd0, (exp == 32'd0)});
          n_out++;
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(alu_a, alu_b, alu_op));
    end
  end

  // One op from IDLE with out_ready high; checks latency and in_ready-low cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input string tag);
    int lat, busy, waitn, exp_lat;
    exp_lat = exp_latency(b, op);
    out_ready = 1'b1;
    in_valid = 1'b1; alu_a = a; alu_b = b; alu_op = op;
    #1;
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    waitn = 0;
    while (!in_ready && waitn < 100) begin @(posedge clk); #1; waitn++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy, exp_lat - 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, base;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op(32'h7FFF_FFFF, 32'h0000_0001, c_ADD, "add_ovf");
    do_op(32'd5, 32'd5, c_SUB, "sub_zero");
    do_op(32'hFFFF_FFFF, 32'd1, c_SLT, "slt");
    do_op(32'hFFFF_FFFF, 32'd1, c_SLTU, "sltu");
    do_op(32'h8000_0000, 32'd4, c_SRA, "sra4");
    do_op(32'h0001_2345, 32'd12, c_SLL, "lui_sll");
    do_op(32'hDEAD_BEEF, 32'h0000_0020, c_SLL, "sll_sh0");
    do_op(32'h8000_00F0, 32'hFFFF_FFE3, c_SRA, "sra_hi_ign");
    do_op(32'hF0F0_1234, 32'd31, c_SRL, "srl31");
    do_op(32'hA5A5_A5A5, 32'h0F0F_FFFF, c_XOR, "xor");
    do_op(32'h1200_0034, 32'h0045_6000, c_OR, "or");
    do_op(32'hFF00_FF00, 32'h0FF0_0FF0, c_AND, "and");
    do_op(32'h1234_5678, 32'h1111_1111, 4'b1001, "illegal9");
    do_op(32'h1234_5678, 32'h1111_1111, 4'b1111, "illegalF");

    // Backpressure: 3+4 held for 4 cycles; a pending op must be ignored.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_a = 32'd3; alu_b = 32'd4; alu_op = c_ADD;
    @(posedge clk); #1;
    alu_a = 32'd100; alu_b = 32'd200;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, 32'd7);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming: 8 back-to-back ADDs, one accepted per cycle.
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      alu_a = 32'h1000_0000 * i + 32'd17;
      alu_b = 32'h0101_0101 * (i + 3);
      alu_op = c_ADD;
      #1;
      check("stream_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", n_out - base, 32'd8);
    check("stream_sb_empty", sb_q.size(), 32'd0);

    // Reset on cycle 3 of an SRL by 20.
    in_valid = 1'b1; alu_a = 32'hFEDC_BA98; alu_b = 32'd20; alu_op = c_SRL;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("no_stale_valid", seen, 32'd0);
    check("no_stale_result", result, 32'd0);

    // First accept right after a reset release.
    rst = 1'b1; #3 rst = 1'b0;
    do_op(32'd9, 32'd1, c_SRL, "post_rst");

    check("final_sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
